// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode and
// per-class execute/memory/writeback states, with memory handshake via mem_ready.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic [1:0] pcsrc,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdest,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       retire,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC_R  = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDI_EX = 4'd9,
        ADDI_WB = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] opc_q, opc_d;

    // zero only qualifies the datapath's PC write through pcwritecond.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        pcsrc       = 2'b00;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        regdest     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        retire      = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                opc_d   = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opc_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                retire   = mem_ready;
                if (mem_ready) state_d = FETCH;
            end
            EXEC_R: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdest  = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsrc       = 2'b01;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            ADDI_EX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Outputs are held quiet for the whole reset window, FETCH strobes included.
        if (!rst_n) begin
            iord        = 1'b0;
            irwrite     = 1'b0;
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            pcsrc       = 2'b00;
            memread     = 1'b0;
            memwrite    = 1'b0;
            memtoreg    = 1'b0;
            regdest     = 1'b0;
            regwrite    = 1'b0;
            alusrca     = 1'b0;
            alusrcb     = 2'b00;
            aluop       = 2'b00;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle sequences built
// from the instruction-class rules, driven with random waits and don't-care inputs.
module tb_multicycle_control;

    typedef struct packed {
        logic       iord, irwrite, pcwrite, pcwritecond;
        logic [1:0] pcsrc;
        logic       memread, memwrite, memtoreg, regdest, regwrite, alusrca;
        logic [1:0] alusrcb, aluop;
        logic       retire, illegal;
    } ctl_t;

    typedef struct {
        ctl_t exp;
        logic mr;
        logic dec;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       iord, irwrite, pcwrite, pcwritecond, memread, memwrite;
    logic       memtoreg, regdest, regwrite, alusrca, retire, illegal;
    logic [1:0] pcsrc, alusrcb, aluop;
    ctl_t       outs;

    int checks = 0;
    int failures = 0;
    int retires = 0;
    item_t q[$];

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
        .pcsrc(pcsrc), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .regdest(regdest), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .retire(retire), .illegal(illegal)
    );

    assign outs = {iord, irwrite, pcwrite, pcwritecond, pcsrc, memread, memwrite,
                   memtoreg, regdest, regwrite, alusrca, alusrcb, aluop, retire, illegal};

    always #5 clk = ~clk;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input ctl_t e, input logic mr, input logic dec);
        item_t it;
        it.exp = e;
        it.mr  = mr;
        it.dec = dec;
        q.push_back(it);
    endfunction

    // One clock cycle: drive inputs, compare on the falling edge, advance.
    task automatic step(input ctl_t exp, input logic mr, input logic [5:0] op,
                        input logic z, input logic rn, input string tag);
        mem_ready = mr;
        opcode    = op;
        zero      = z;
        rst_n     = rn;
        @(negedge clk);
        checks++;
        if (outs.retire) retires++;
        assert (outs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, outs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle controls for one instruction: f fetch waits, m data waits.
    // rst_at >= 0 abandons the instruction with a one-cycle reset at that cycle index.
    task automatic run_instr(input logic [5:0] op, input int f, input int m, input logic z,
                             input int rst_at, input string tag);
        ctl_t c;
        q.delete();
        for (int i = 0; i < f; i++) begin
            c = '0; c.memread = 1; c.alusrcb = 2'b01;
            push(c, 1'b0, 1'b0);
        end
        c = '0; c.memread = 1; c.alusrcb = 2'b01; c.irwrite = 1; c.pcwrite = 1;
        push(c, 1'b1, 1'b0);
        c = '0; c.alusrcb = 2'b11;
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: ;
            default: c.illegal = 1;
        endcase
        push(c, rbit(), 1'b1);
        case (op)
            6'b100011, 6'b101011: begin
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10;
                push(c, rbit(), 1'b0);
                for (int i = 0; i <= m; i++) begin
                    c = '0; c.iord = 1;
                    if (op == 6'b100011) c.memread = 1;
                    else begin
                        c.memwrite = 1;
                        c.retire = (i == m);
                    end
                    push(c, (i == m), 1'b0);
                end
                if (op == 6'b100011) begin
                    c = '0; c.regwrite = 1; c.memtoreg = 1; c.retire = 1;
                    push(c, rbit(), 1'b0);
                end
            end
            6'b000000: begin
                c = '0; c.alusrca = 1; c.aluop = 2'b10;
                push(c, rbit(), 1'b0);
                c = '0; c.regwrite = 1; c.regdest = 1; c.retire = 1;
                push(c, rbit(), 1'b0);
            end
            6'b001000: begin
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10;
                push(c, rbit(), 1'b0);
                c = '0; c.regwrite = 1; c.retire = 1;
                push(c, rbit(), 1'b0);
            end
            6'b000100: begin
                c = '0; c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1;
                c.pcsrc = 2'b01; c.retire = 1;
                push(c, rbit(), 1'b0);
            end
            6'b000010: begin
                c = '0; c.pcwrite = 1; c.pcsrc = 2'b10; c.retire = 1;
                push(c, rbit(), 1'b0);
            end
            default: ;
        endcase
        for (int i = 0; i < q.size(); i++) begin
            if (i == rst_at) begin
                step('0, 1'b0, 6'($urandom), z, 1'b0, {tag, "_rst"});
                break;
            end
            step(q[i].exp, q[i].mr, q[i].dec ? op : 6'($urandom), z, 1'b1, tag);
        end
    endtask

    initial begin
        logic [5:0] ops[7];
        int r0;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};

        #1;
        step('0, rbit(), 6'($urandom), rbit(), 1'b0, "reset0");
        step('0, rbit(), 6'($urandom), rbit(), 1'b0, "reset1");

        run_instr(6'b100011, 0, 0, 1'b0, -1, "lw_nowait");
        run_instr(6'b101011, 0, 3, 1'b0, -1, "sw_wait3");
        run_instr(6'b000100, 0, 0, 1'b0, -1, "beq_z0");
        run_instr(6'b000100, 1, 0, 1'b1, -1, "beq_z1");
        run_instr(6'b111111, 0, 0, 1'b0, -1, "illegal");
        run_instr(6'b100011, 1, 6, 1'b0, 6, "lw_rst_memrd");
        run_instr(6'b101011, 0, 5, 1'b0, 5, "sw_rst_memwr");

        r0 = retires;
        run_instr(6'b000000, 2, 0, 1'b0, -1, "rtype_f2");
        run_instr(6'b001000, 2, 0, 1'b0, -1, "addi_f2");
        run_instr(6'b000010, 2, 0, 1'b0, -1, "j_f2");
        checks++;
        assert (retires - r0 === 3) else begin
            failures++;
            $error("FAIL retire_count got=%0d exp=3", retires - r0);
        end

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rbit(),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- opcode  in  6  instruction[31:26]; sampled in DECODE only.
- zero  in  1  ALU zero flag; used in BRANCH only.
- mem_ready  in  1  memory handshake; the access completes in the cycle it is high while memread or memwrite is high.
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- irwrite  out  1  load the instruction register.
- pcwrite  out  1  unconditional PC write.
- pcwritecond  out  1  PC write qualified by zero.
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- memread, memwrite  out  1 each  memory strobes; held until mem_ready.
- memtoreg, regdest, regwrite  out  1 each  register-file write controls.
- alusrca  out  1  ALU A source: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B source: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- aluop  out  2  ALU operation: 00 = add, 01 = subtract, 10 = use the funct field.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-002 SHALL be a Moore FSM: every output SHALL be a function of the current state only, except pcwrite, irwrite and retire, which SHALL additionally depend on mem_ready or zero where stated below.
REQ-003 SHALL support these opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-004 SHALL drive 0 on every output not listed for the current state.
REQ-005 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready; stay while mem_ready=0; go to DECODE when mem_ready=1.
REQ-006 DECODE: alusrca=0, alusrcb=11, aluop=00; next state by opcode: lw/sw -> MEMADR, R-type -> EXEC_R, beq -> BRANCH, addi -> ADDI_EX, j -> JUMP, any other -> FETCH with illegal=1 for that cycle.
REQ-007 MEMADR: alusrca=1, alusrcb=10, aluop=00; next state MEMRD for lw, MEMWR for sw; opcode SHALL be held in an internal register captured in DECODE.
REQ-008 MEMRD: memread=1, iord=1; wait for mem_ready, then go to MEMWB.
REQ-009 MEMWB: regwrite=1, memtoreg=1, regdest=0, retire=1; go to FETCH.
REQ-010 MEMWR: memwrite=1, iord=1; retire=mem_ready; wait for mem_ready, then go to FETCH.
REQ-011 EXEC_R: alusrca=1, alusrcb=00, aluop=10; go to ALUWB.
REQ-012 ALUWB: regwrite=1, regdest=1, memtoreg=0, retire=1; go to FETCH.
REQ-013 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsrc=01; the PC is updated only when zero=1; retire=1; go to FETCH.
REQ-014 ADDI_EX: alusrca=1, alusrcb=10, aluop=00; go to ADDI_WB.
REQ-015 ADDI_WB: regwrite=1, regdest=0, memtoreg=0, retire=1; go to FETCH.
REQ-016 JUMP: pcwrite=1, pcsrc=10, retire=1; go to FETCH.
REQ-017 Instruction latency SHALL be, with zero wait states (F = fetch wait cycles, M = data wait cycles):
- lw: 5+F+M cycles.
- sw: 4+F+M cycles.
- R-type and addi: 4+F cycles.
- beq and j: 3+F cycles.
REQ-018 memread and memwrite SHALL never be high in the same cycle, and SHALL stay stable while waiting for mem_ready.
REQ-019 mem_ready SHALL be ignored in states without a memory strobe.
REQ-020 retire and illegal SHALL never both be high, and each SHALL be high for at most one cycle per instruction.
REQ-021 Unreachable or unencoded state values SHALL return to FETCH on the next clock edge, with all outputs driven to 0.

Reset
REQ-022 When rst_n=0 at a rising clk edge, the state SHALL become FETCH and the latched opcode SHALL become 000000, regardless of the current state, including mid-wait in MEMRD or MEMWR.
REQ-023 During reset, every output SHALL be 0 except the FETCH-state Moore outputs, which become active starting the first cycle with rst_n=1.
REQ-024 Reset SHALL not depend on mem_ready; an access that was outstanding when reset was asserted SHALL be abandoned.

Verification
REQ-025 lw, mem_ready constantly 1: state trace FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; retire is a single pulse in cycle 5.
REQ-026 sw with mem_ready held at 0 for 3 cycles in MEMWR: memwrite=1 for 4 consecutive cycles; retire=1 only in the cycle with mem_ready=1; never regwrite.
REQ-027 beq with zero=0, then with zero=1: pcwritecond=1 and pcsrc=01 in BRANCH both times; FETCH follows 3 cycles after FETCH exit.
REQ-028 opcode 111111 in DECODE: illegal=1 for one cycle; next state FETCH; no regwrite, memwrite or retire.
REQ-029 rst_n=0 for one cycle while in MEMRD waiting (mem_ready=0): the next state is FETCH; memread keeps iord=0 after reset; no retire.
REQ-030 Back-to-back R-type, addi, j, with 2 fetch wait cycles each: exact latencies 6, 6, 5 cycles; exactly three retire pulses.
